// File: rtl/pio_cmd_arb_if.sv
// rtl/pio_cmd_arb_if.sv - requester, response and pio command-port signals of pio_cmd_arb
interface pio_cmd_arb_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]    req_valid;
    logic [4*NREQ-1:0]  req_action;
    logic [2*NREQ-1:0]  req_mindex;
    logic [5*NREQ-1:0]  req_index;
    logic [32*NREQ-1:0] req_din;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [31:0]        rsp_data;
    logic [3:0]         pio_action;
    logic [1:0]         pio_mindex;
    logic [4:0]         pio_index;
    logic [31:0]        pio_din;
    logic [31:0]        pio_dout;
    logic [3:0]         tx_full;
    logic [3:0]         rx_empty;
    logic               busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_action, req_mindex, req_index, req_din, req_lock,
        input  pio_dout, tx_full, rx_empty,
        output req_ready, rsp_valid, rsp_data,
        output pio_action, pio_mindex, pio_index, pio_din, busy
    );

    // Requester / pio side
    modport master (
        output req_valid, req_action, req_mindex, req_index, req_din, req_lock,
        output pio_dout, tx_full, rx_empty,
        input  req_ready, rsp_valid, rsp_data,
        input  pio_action, pio_mindex, pio_index, pio_din, busy
    );
endinterface

// File: rtl/pio_cmd_arb.sv
// rtl/pio_cmd_arb.sv - round-robin command arbiter for one pio command port; PIO_CMD_ARB_LOCK_EN enables grant locking
module pio_cmd_arb #(
    parameter int         NREQ     = 3,
    parameter logic [3:0] ACT_IDLE = 4'd0,
    parameter logic [3:0] ACT_PUSH = 4'd4,
    parameter logic [3:0] ACT_PULL = 4'd5
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    pio_cmd_arb_if.slave bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_rr;
    logic [GW-1:0]   r_gnt;
    logic [NREQ-1:0] r_req_ready;
    logic [NREQ-1:0] r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic [3:0]      r_pio_action;
    logic [1:0]      r_pio_mindex;
    logic [4:0]      r_pio_index;
    logic [31:0]     r_pio_din;
    logic            r_busy;

    logic [NREQ-1:0] w_elig;
    logic            w_pick_found;
    logic [GW-1:0]   w_pick;
    logic [GW:0]     w_slot;
    logic [GW-1:0]   w_sel;
    logic [NREQ-1:0] w_sel_onehot;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [3:0]      w_sel_action;
    logic [1:0]      w_sel_mindex;
    logic [4:0]      w_sel_index;
    logic [31:0]     w_sel_din;
    logic [GW-1:0]   w_rr_next;

    // A requester is eligible unless its push/pull targets a FIFO that cannot take it
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = bus.req_valid[i]
                && !((bus.req_action[4*i +: 4] == ACT_PUSH) && bus.tx_full[bus.req_mindex[2*i +: 2]])
                && !((bus.req_action[4*i +: 4] == ACT_PULL) && bus.rx_empty[bus.req_mindex[2*i +: 2]]);
        end
    end

    // First eligible requester at or after the round-robin pointer, wrapping modulo NREQ
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_slot       = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_slot = {1'b0, r_rr} + (GW+1)'(k);
            if (w_slot >= (GW+1)'(NREQ)) begin
                w_slot = w_slot - (GW+1)'(NREQ);
            end
            if (!w_pick_found && w_elig[w_slot[GW-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick       = w_slot[GW-1:0];
            end
        end
    end

    // Fields of the requester about to be issued: the new pick from IDLE, the held grant from RESP
    always_comb begin
        w_sel        = (r_state == S_RESP) ? r_gnt : w_pick;
        w_sel_onehot = '0;
        w_gnt_onehot = '0;
        w_sel_action = ACT_IDLE;
        w_sel_mindex = '0;
        w_sel_index  = '0;
        w_sel_din    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_sel == GW'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_action    = bus.req_action[4*i +: 4];
                w_sel_mindex    = bus.req_mindex[2*i +: 2];
                w_sel_index     = bus.req_index[5*i +: 5];
                w_sel_din       = bus.req_din[32*i +: 32];
            end
            if (r_gnt == GW'(i)) begin
                w_gnt_onehot[i] = 1'b1;
            end
        end
    end

    assign w_rr_next = (r_gnt == GW'(NREQ - 1)) ? '0 : r_gnt + GW'(1);

`ifndef PIO_CMD_ARB_LOCK_EN
    logic w_unused_lock;
    assign w_unused_lock = ^bus.req_lock;
`endif

    // IDLE -> ISSUE -> RESP sequencer; every output is registered and defaults to its idle value
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_rr         <= '0;
            r_gnt        <= '0;
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_pio_action <= ACT_IDLE;
            r_pio_mindex <= '0;
            r_pio_index  <= '0;
            r_pio_din    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_req_ready  <= '0;
            r_rsp_valid  <= '0;
            r_pio_action <= ACT_IDLE;
            r_pio_mindex <= '0;
            r_pio_index  <= '0;
            r_pio_din    <= '0;
            r_busy       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_gnt        <= w_pick;
                        r_req_ready  <= w_sel_onehot;
                        r_pio_action <= w_sel_action;
                        r_pio_mindex <= w_sel_mindex;
                        r_pio_index  <= w_sel_index;
                        r_pio_din    <= w_sel_din;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The pio answers while the action is applied, so dout is taken at the end of ISSUE
                    r_rsp_valid <= w_gnt_onehot;
                    r_rsp_data  <= bus.pio_dout;
                    r_busy      <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
`ifdef PIO_CMD_ARB_LOCK_EN
                    if (bus.req_lock[r_gnt] && w_elig[r_gnt]) begin
                        // Locked requester keeps the port; pointer stays put
                        r_req_ready  <= w_sel_onehot;
                        r_pio_action <= w_sel_action;
                        r_pio_mindex <= w_sel_mindex;
                        r_pio_index  <= w_sel_index;
                        r_pio_din    <= w_sel_din;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end else begin
                        r_rr    <= w_rr_next;
                        r_state <= S_IDLE;
                    end
`else
                    r_rr    <= w_rr_next;
                    r_state <= S_IDLE;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.pio_action = r_pio_action;
    assign bus.pio_mindex = r_pio_mindex;
    assign bus.pio_index  = r_pio_index;
    assign bus.pio_din    = r_pio_din;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_pio_cmd_arb.sv
// tb/tb_pio_cmd_arb.sv - self-checking bench for pio_cmd_arb (directed scenarios plus randomized model check)
module tb_pio_cmd_arb;
    localparam int NREQ = 3;

    logic clk = 1'b0;
    logic rst;
    int   total;
    int   bad;

    always #5 clk = ~clk;

    pio_cmd_arb_if #(.NREQ(NREQ)) bus();

    pio_cmd_arb #(
        .NREQ(NREQ), .ACT_IDLE(4'd0), .ACT_PUSH(4'd4), .ACT_PULL(4'd5)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus(bus.slave)
    );

    logic        s_valid [NREQ];
    logic [3:0]  s_act   [NREQ];
    logic [1:0]  s_midx  [NREQ];
    logic [4:0]  s_idx   [NREQ];
    logic [31:0] s_din   [NREQ];
    logic        s_lock  [NREQ];
    logic [3:0]  s_txf;
    logic [3:0]  s_rxe;

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]           = s_valid[i];
            bus.req_action[4*i +: 4]   = s_act[i];
            bus.req_mindex[2*i +: 2]   = s_midx[i];
            bus.req_index[5*i +: 5]    = s_idx[i];
            bus.req_din[32*i +: 32]    = s_din[i];
            bus.req_lock[i]            = s_lock[i];
        end
        bus.tx_full  = s_txf;
        bus.rx_empty = s_rxe;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NREQ; i++) begin
            s_valid[i] = 1'b0; s_act[i] = 4'd0; s_midx[i] = 2'd0;
            s_idx[i] = 5'd0; s_din[i] = 32'd0; s_lock[i] = 1'b0;
        end
        s_txf = 4'd0;
        s_rxe = 4'd0;
        apply();
    endtask

    task automatic set_cmd(input int i, input logic [3:0] act, input logic [1:0] mi, input logic [4:0] ix, input logic [31:0] d);
        s_valid[i] = 1'b1; s_act[i] = act; s_midx[i] = mi; s_idx[i] = ix; s_din[i] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -2;
    endfunction

    task automatic wait_ready(input int limit, output int g, output int n);
        g = -1;
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (bus.req_ready != '0) begin
                g = onehot_idx(bus.req_ready);
                break;
            end
        end
    endtask

    function automatic bit elig(input int i);
        if (!s_valid[i]) return 1'b0;
        if (s_act[i] == 4'd4 && s_txf[s_midx[i]]) return 1'b0;
        if (s_act[i] == 4'd5 && s_rxe[s_midx[i]]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        clear_stim();
        bus.pio_dout = 32'hDEAD_BEEF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
        total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        total++; if ({bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din} !== 43'd0) begin bad++;
            $display("FAIL reset_pio: got act=%h mi=%h ix=%h din=%h want all 0", bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_stim();
        do_reset();
        set_cmd(1, 4'd1, 2'd0, 5'd5, 32'h0000_A0B1);
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 3'b010) begin bad++; $display("FAIL single_ready: got %b want 010", bus.req_ready); end
        total++; if ({bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din} !== {4'd1, 2'd0, 5'd5, 32'h0000_A0B1}) begin bad++;
            $display("FAIL single_pio: got act=%h mi=%h ix=%h din=%h want 1/0/5/0000a0b1", bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy_issue: got %b want 1", bus.busy); end
        total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL single_rsp_early: got %b want 0", bus.rsp_valid); end
        s_valid[1] = 1'b0;
        apply();
        bus.pio_dout = 32'h0000_1234;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 3'b010) begin bad++; $display("FAIL single_rsp_valid: got %b want 010", bus.rsp_valid); end
        total++; if (bus.rsp_data !== 32'h1234) begin bad++; $display("FAIL single_rsp_data: got %h want 00001234", bus.rsp_data); end
        total++; if (bus.pio_action !== 4'd0 || bus.pio_din !== 32'd0) begin bad++;
            $display("FAIL single_pio_resp: got act=%h din=%h want 0/0", bus.pio_action, bus.pio_din); end
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL single_ready_once: got %b want 0", bus.req_ready); end
        bus.pio_dout = 32'h5555_0000;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin bad++;
            $display("FAIL single_idle: got busy=%b rsp_valid=%b want 0/0", bus.busy, bus.rsp_valid); end
        total++; if (bus.rsp_data !== 32'h1234) begin bad++; $display("FAIL single_rsp_hold: got %h want 00001234", bus.rsp_data); end
    endtask

    task automatic test_contention();
        int g, n;
        clear_stim();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 4'd1, 2'(i), 5'(i), 32'h100 + 32'(i));
        apply();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            wait_ready(6, g, n);
            total++; if (g !== k % NREQ) begin bad++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, g, k % NREQ); end
            total++; if (n !== ((k == 0) ? 1 : 3)) begin bad++; $display("FAIL contention_gap[%0d]: got %0d want %0d", k, n, (k == 0) ? 1 : 3); end
            total++; if (bus.pio_din !== 32'h100 + 32'(k % NREQ)) begin bad++;
                $display("FAIL contention_din[%0d]: got %h want %h", k, bus.pio_din, 32'h100 + 32'(k % NREQ)); end
        end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall_skip();
        int g, n;
        clear_stim();
        set_cmd(0, 4'd4, 2'd2, 5'd0, 32'hAAAA_0000);
        set_cmd(1, 4'd1, 2'd0, 5'd1, 32'hBBBB_0000);
        s_txf = 4'b0100;
        apply();
        do_reset();
        wait_ready(6, g, n);
        total++; if (g !== 1 || n !== 1) begin bad++; $display("FAIL stall_skip_first: got req=%0d after %0d want req=1 after 1", g, n); end
        s_valid[1] = 1'b0;
        s_txf = 4'b0000;
        apply();
        wait_ready(6, g, n);
        total++; if (g !== 0 || n !== 3) begin bad++; $display("FAIL stall_skip_second: got req=%0d after %0d want req=0 after 3", g, n); end
        total++; if (bus.pio_action !== 4'd4 || bus.pio_mindex !== 2'd2) begin bad++;
            $display("FAIL stall_skip_fields: got act=%h mi=%h want 4/2", bus.pio_action, bus.pio_mindex); end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pull_empty();
        clear_stim();
        set_cmd(0, 4'd5, 2'd0, 5'd3, 32'h0);
        s_rxe = 4'b0001;
        apply();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (bus.req_ready !== '0 || bus.busy !== 1'b0) begin bad++;
                $display("FAIL pull_empty_wait[%0d]: got ready=%b busy=%b want 0/0", c, bus.req_ready, bus.busy); end
        end
        s_rxe = 4'b1110;
        apply();
        @(negedge clk);
        total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL pull_empty_release: got %b want 001", bus.req_ready); end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int g, n;
        clear_stim();
        do_reset();
        set_cmd(1, 4'd1, 2'd1, 5'd1, 32'h1111);
        apply();
        wait_ready(4, g, n);
        total++; if (g !== 1) begin bad++; $display("FAIL rstmid_pre: got %0d want 1", g); end
        s_valid[1] = 1'b0;
        set_cmd(2, 4'd2, 2'd3, 5'd9, $urandom);
        apply();
        wait_ready(6, g, n);
        total++; if (g !== 2 || n !== 3) begin bad++; $display("FAIL rstmid_issue: got req=%0d after %0d want req=2 after 3", g, n); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.rsp_valid !== '0) begin bad++; $display("FAIL rstmid_no_rsp: got %b want 0", bus.rsp_valid); end
        total++; if (bus.pio_action !== 4'd0 || bus.busy !== 1'b0 || bus.req_ready !== '0) begin bad++;
            $display("FAIL rstmid_idle: got act=%h busy=%b ready=%b want 0/0/0", bus.pio_action, bus.busy, bus.req_ready); end
        total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL rstmid_rsp_data: got %h want 0", bus.rsp_data); end
        rst = 1'b0;
        set_cmd(1, 4'd1, 2'd0, 5'd0, 32'h2222);
        apply();
        wait_ready(4, g, n);
        total++; if (g !== 1 || n !== 1) begin bad++; $display("FAIL rstmid_rr_zero: got req=%0d after %0d want req=1 after 1", g, n); end
        @(negedge clk);
        total++; if (bus.rsp_valid !== 3'b010) begin bad++; $display("FAIL rstmid_rsp_after: got %b want 010", bus.rsp_valid); end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lock();
        int g, n;
        clear_stim();
        do_reset();
        set_cmd(2, 4'd1, 2'd0, 5'd0, 32'd100);
        s_lock[2] = 1'b1;
        apply();
        wait_ready(4, g, n);
        total++; if (g !== 2) begin bad++; $display("FAIL lock_first: got %0d want 2", g); end
        set_cmd(0, 4'd1, 2'd0, 5'd0, 32'd200);
`ifdef PIO_CMD_ARB_LOCK_EN
        s_din[2] = 32'd101;
        apply();
        for (int c = 1; c < 4; c++) begin
            wait_ready(6, g, n);
            total++; if (g !== 2 || n !== 2) begin bad++; $display("FAIL lock_chain[%0d]: got req=%0d after %0d want req=2 after 2", c, g, n); end
            total++; if (bus.pio_din !== 32'd100 + 32'(c)) begin bad++; $display("FAIL lock_din[%0d]: got %0d want %0d", c, bus.pio_din, 100 + c); end
            s_din[2] = 32'd101 + 32'(c);
            if (c == 3) begin
                s_lock[2]  = 1'b0;
                s_valid[2] = 1'b0;
            end
            apply();
        end
`else
        apply();
`endif
        wait_ready(6, g, n);
        total++; if (g !== 0 || n !== 3) begin bad++; $display("FAIL lock_release: got req=%0d after %0d want req=0 after 3", g, n); end
        clear_stim();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int          m_rr, m_free, m_iss, m_rsp, m_g, just;
        logic [31:0] m_dout, m_last;
        logic [42:0] m_fields, exp_pio;
        logic [NREQ-1:0] exp_ready, exp_rv;
        clear_stim();
        bus.pio_dout = 32'd0;
        do_reset();
        m_rr = 0; m_free = 1; m_iss = -10; m_rsp = -10; m_g = 0;
        m_dout = 32'd0; m_last = 32'd0; m_fields = '0;
        for (int cyc = 1; cyc <= 1500; cyc++) begin
            @(negedge clk);
            exp_ready = '0;
            exp_rv    = '0;
            exp_pio   = '0;
            if (cyc == m_iss) begin exp_ready[m_g] = 1'b1; exp_pio = m_fields; end
            if (cyc == m_rsp) begin exp_rv[m_g] = 1'b1; m_last = m_dout; end
            total++; if (bus.req_ready !== exp_ready) begin bad++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, bus.req_ready, exp_ready); end
            total++; if ({bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din} !== exp_pio) begin bad++;
                $display("FAIL rand_pio@%0d: got %h want %h", cyc, {bus.pio_action, bus.pio_mindex, bus.pio_index, bus.pio_din}, exp_pio); end
            total++; if (bus.rsp_valid !== exp_rv) begin bad++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, bus.rsp_valid, exp_rv); end
            total++; if (bus.rsp_data !== m_last) begin bad++; $display("FAIL rand_rsp_data@%0d: got %h want %h", cyc, bus.rsp_data, m_last); end
            total++; if (bus.busy !== (cyc == m_iss || cyc == m_rsp)) begin bad++;
                $display("FAIL rand_busy@%0d: got %b want %b", cyc, bus.busy, (cyc == m_iss || cyc == m_rsp)); end
            bus.pio_dout = $urandom;
            if (cyc == m_iss) m_dout = bus.pio_dout;
            just = (cyc == m_iss) ? m_g : -1;
            for (int i = 0; i < NREQ; i++) begin
                if (i == just || !s_valid[i]) begin
                    if ((i == just) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 2) == 0)) begin
                        case ($urandom_range(0, 3))
                            0:       s_act[i] = 4'd4;
                            1:       s_act[i] = 4'd5;
                            default: s_act[i] = 4'($urandom_range(0, 7));
                        endcase
                        s_valid[i] = 1'b1;
                        s_midx[i] = 2'($urandom); s_idx[i] = 5'($urandom);
                        s_din[i] = $urandom; s_lock[i] = 1'($urandom);
                    end else begin
                        s_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    s_valid[i] = 1'b0;
                end
            end
            s_txf = 4'($urandom & $urandom);
            s_rxe = 4'($urandom & $urandom);
            apply();
`ifdef PIO_CMD_ARB_LOCK_EN
            if (cyc == m_rsp && s_lock[m_g] && elig(m_g)) begin
                m_iss = cyc + 1; m_rsp = cyc + 2; m_free = cyc + 3;
                m_fields = {s_act[m_g], s_midx[m_g], s_idx[m_g], s_din[m_g]};
            end else
`endif
            if (cyc >= m_free) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (elig((m_rr + k) % NREQ)) begin
                        m_g = (m_rr + k) % NREQ;
                        m_iss = cyc + 1; m_rsp = cyc + 2; m_free = cyc + 3;
                        m_fields = {s_act[m_g], s_midx[m_g], s_idx[m_g], s_din[m_g]};
                        m_rr = (m_g + 1) % NREQ;
                        break;
                    end
                end
            end
        end
        clear_stim();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.pio_dout = 32'd0;
        clear_stim();
        test_reset();
        test_single();
        test_contention();
        test_stall_skip();
        test_pull_empty();
        test_reset_mid_op();
        test_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pio_cmd_arb.md
# pio_cmd_arb

Round-robin arbiter and sequencer for the command port of one `pio` instance (`action` / `mindex` / `index` / `din` → `dout`). It lets NREQ requesters share that port, for example the Wishbone bridge, a program loader and a FIFO pump. Each requester's command is issued as a single-cycle action and the PIO's `dout` is returned to that requester only. Push/pull commands whose target FIFO cannot accept them are skipped, so one blocked requester cannot stall the others.

## Interface
Parameters:
- `NREQ`, 3: number of requesters, 2..8.
- `ACT_IDLE`, 4'd0: action code driven to the PIO when no command is issued.
- `ACT_PUSH`, 4'd4: TX FIFO push action; not eligible while `tx_full[mindex]`.
- `ACT_PULL`, 4'd5: RX FIFO pull action; not eligible while `rx_empty[mindex]`.

Ports:
- `wb_clk_i`  in  1  clock; all logic on its rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  per-requester command valid.
- `req_action`  in  4*NREQ  action code; requester i uses bits [4i+3:4i].
- `req_mindex`  in  2*NREQ  state machine index.
- `req_index`  in  5*NREQ  instruction index.
- `req_din`  in  32*NREQ  command data.
- `req_lock`  in  NREQ  keep the grant after this command (PIO_CMD_ARB_LOCK_EN only).
- `req_ready`  out  NREQ  one-hot pulse; the command was issued this cycle.
- `rsp_valid`  out  NREQ  one-hot pulse; `rsp_data` is valid for that requester.
- `rsp_data`  out  32  captured `pio_dout`.
- `pio_action`  out  4  action to the PIO.
- `pio_mindex`  out  2  machine index to the PIO.
- `pio_index`  out  5  instruction index to the PIO.
- `pio_din`  out  32  data to the PIO.
- `pio_dout`  in  32  data from the PIO.
- `tx_full`  in  4  per-machine TX FIFO full.
- `rx_empty`  in  4  per-machine RX FIFO empty.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Eligibility: requester i is eligible when `req_valid[i]` is high and its action is not ACT_PUSH with `tx_full[mindex_i]` high, and not ACT_PULL with `rx_empty[mindex_i]` high.
- States:
  - IDLE: if any requester is eligible, grant the first eligible one at or after pointer `rr` (mod NREQ), register the grant, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): drive the granted requester's fields onto `pio_*` and pulse `req_ready[g]`. Go to RESP.
  - RESP (1 cycle): `pio_action` is ACT_IDLE. Latch `pio_dout` into `rsp_data` and pulse `rsp_valid[g]`. Set `rr` to (g+1) mod NREQ. Go to IDLE.
- Outside ISSUE, `pio_action` is ACT_IDLE, and `pio_mindex`, `pio_index` and `pio_din` are 0.
- Requester rules:
  - Fields must be held stable from valid until the `req_ready` cycle.
  - Dropping `req_valid` before ready withdraws the request; this is legal.
  - Re-asserting in the cycle after `rsp_valid` is allowed.
- Eligibility is evaluated only in IDLE. A FIFO flag that changes during ISSUE does not cancel the command.
- `rsp_data` holds its value until the next RESP cycle.
- Reset, including in the middle of a command:
  - state goes to IDLE and `rr` to 0.
  - `req_ready` and `rsp_valid` go to 0, and `rsp_data` to 0.
  - `pio_action` goes to ACT_IDLE and the other `pio_*` outputs to 0; `busy` goes to 0.
  - An in-flight command produces no response.

## Timing
- Latency from eligible request to `req_ready` is 1 cycle when uncontended: eligible in IDLE at cycle n, ISSUE at n+1.
- `rsp_valid` follows at n+2, so it always comes exactly 1 cycle after `req_ready`.
- Throughput is one command per 3 cycles, or 2 cycles back-to-back under lock.
- Worst-case wait for a continuously eligible requester is (NREQ-1) commands.
- All outputs are registered.

## Configuration
- `PIO_CMD_ARB_LOCK_EN` defined:
  - In RESP, if `req_lock[g]` is high and requester g is eligible, go directly to ISSUE for g, skipping IDLE.
  - `rr` is not advanced.
  - Used for contiguous program loads.
- Not defined: `req_lock` is ignored, and every command returns through IDLE with round-robin advance.

## Test plan
- Single request: NREQ=3, requester 1 sends action 1, index 5, din 0x0000_A0B1 → `pio_action`=1, `pio_index`=5 and `pio_din`=0x0000A0B1 for exactly 1 cycle, with `req_ready[1]` in the same cycle. With `pio_dout`=0x1234 → `rsp_valid[1]` 1 cycle later and `rsp_data`=0x1234.
- Contention: all 3 requesters held valid from reset → grant order 0,1,2,0,1,2, with `req_ready` pulses 3 cycles apart.
- Stall skip: requester 0 does ACT_PUSH to mindex 2 with `tx_full`=4'b0100, requester 1 valid → requester 1 is served. Clear `tx_full` → requester 0 is served next.
- Pull on empty: ACT_PULL with `rx_empty[0]`=1 → no `req_ready` for 10 cycles and `busy`=0. Clear the flag → issued within 1 cycle.
- Reset mid-op: assert `wb_rst_i` during ISSUE → no `rsp_valid`, and the next cycle shows `pio_action`=ACT_IDLE, `busy`=0, `rr`=0.
- Lock (macro defined): requester 2 issues 4 commands with `req_lock` high while requester 0 waits → `req_ready[2]` pulses 2 cycles apart, then requester 0 is granted after the lock drops.
